reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised scoreboarded register file: the successor to the single-port-pair register file used in instruction decode and write-back. It provides two registered read ports, one write-back port, per-register busy (pending-write) tracking for the pipelined core, optional write-to-read bypass, and a hardware-zero register 0. After reset it clears the storage array with a sweep, so the array can map to RAM. It sits between decode/issue (reads, claims) and write-back (writes).

## Interface
- LEN, 32, data width of each register
- DEPTH, 32, number of registers; power of two, ≥ 2
- ADDR_W, 5, index width; must equal log2(DEPTH)
- ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never busy

- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- rdy_in  in  1  global enable; 0 freezes all state and outputs
- rd_en  in  1  capture a read of rs1/rs2 this cycle
- rs1, rs2  in  ADDR_W  read indices
- claim_en  in  1  mark claim_rd busy (an instruction issued that will write it)
- claim_rd  in  ADDR_W  index to mark busy
- wr_en  in  1  write-back strobe
- wr_rd  in  ADDR_W  write-back index
- wr_data  in  LEN  write-back data
- rs1_data, rs2_data  out  LEN  registered read data
- rs1_busy, rs2_busy  out  1  registered busy flags of the captured indices
- init_done  out  1  clear sweep finished; port operations are accepted

## Operation
- States: CLEAR, RUN. Reset → CLEAR with sweep counter = 0 and every busy bit = 0.
- CLEAR: each rdy_in cycle writes 0 to entry[counter] and increments the counter. After entry DEPTH-1 is written → RUN, init_done = 1. rd_en, claim_en and wr_en are ignored; read outputs stay 0.
- RUN, read: when rd_en = 1, rsX_data ← entry[rsX] and rsX_busy ← busy[rsX]. Both ports capture in the same cycle. When rd_en = 0, the outputs hold.
- RUN, write: when wr_en = 1, entry[wr_rd] ← wr_data and busy[wr_rd] ← 0.
- RUN, claim: when claim_en = 1, busy[claim_rd] ← 1.
- Claim and write to the same index in one cycle: the data is written and busy ends at 1 (the claim wins; a new producer is in flight).
- ZERO_REG = 1:
  - Writes and claims to index 0 are dropped.
  - Reads of index 0 return data 0 and busy 0, regardless of bypass.
- Both read ports may address the same index; both return identical values.
- Reset asserted mid-operation, including mid-sweep: busy bits are cleared immediately, init_done drops, and the sweep restarts from 0.

## Timing
- Reset values: rs1_data = rs2_data = 0, rs1_busy = rs2_busy = 0, init_done = 0.
- Sweep length: init_done rises DEPTH rdy_in-cycles after the first edge with rst_n = 1.
- Read latency: 1 cycle. Indices sampled at edge N appear after edge N and hold until the next accepted read.
- Write latency: 1 cycle. A read accepted on the cycle after the write edge sees the new data.
- Claim visibility: a claim at edge N is seen by reads captured at edge N+1 or later (no same-cycle claim forwarding).
- rdy_in = 0: the sweep counter, array, busy bits and outputs are all unchanged.

## Configuration
- RF_BYPASS_EN defined: a read and a write to the same nonzero index in the same cycle returns wr_data, with busy = 0 unless a same-cycle claim also targets that index.
- RF_BYPASS_EN undefined: that read returns the old entry value and the old busy bit. Software/pipeline must then stall one cycle.

## Test plan
- Reset then sweep, DEPTH = 32: init_done = 0 for 32 rdy cycles, then 1. Read of rs1 = 7 → rs1_data = 0, rs1_busy = 0. Drop rdy_in mid-sweep → sweep length extends by the stalled cycles.
- wr_en, wr_rd = 5, wr_data = 0xDEADBEEF; next cycle read rs1 = 5, rs2 = 5 → both ports return 0xDEADBEEF, busy 0. Write index 0 with 0x1234 → a read of index 0 returns 0.
- Claim index 9, read 9 → busy 1. Write 9 = 0x55 → next read returns 0x55, busy 0. Claim and write 9 in the same cycle → next read returns busy 1 and data 0x55.
- Same-cycle write 3 = 0xA5A5A5A5 and read rs1 = 3 (old value 0x11): with RF_BYPASS_EN → 0xA5A5A5A5, busy 0; without → 0x11 and the old busy bit.
- Claim 4, then assert rst_n = 0 for one cycle mid-sweep and mid-operation → busy cleared, outputs 0, init_done 0, and a full 32-cycle sweep repeats.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Issue/write-back bus of the scoreboarded register file: read, claim and write-back signals.
// The master side is decode/write-back; the slave side is the register file.
interface reg_file_sb_if #(
   parameter int LEN    = 32,
   parameter int ADDR_W = 5
);
   logic              rdy_in;
   logic              rd_en;
   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic              claim_en;
   logic [ADDR_W-1:0] claim_rd;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_rd;
   logic [LEN-1:0]    wr_data;
   logic [LEN-1:0]    rs1_data;
   logic [LEN-1:0]    rs2_data;
   logic              rs1_busy;
   logic              rs2_busy;
   logic              init_done;

   modport master (
      output rdy_in, rd_en, rs1, rs2, claim_en, claim_rd, wr_en, wr_rd, wr_data,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, init_done
   );

   modport slave (
      input  rdy_in, rd_en, rs1, rs2, claim_en, claim_rd, wr_en, wr_rd, wr_data,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, init_done
   );
endinterface

// File: rtl/reg_file_sb.sv
// Scoreboarded register file: two registered read ports, one write-back port, busy tracking,
// post-reset clear sweep. Define RF_BYPASS_EN to forward same-cycle write-back data to reads.
module reg_file_sb #(
   parameter int LEN      = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   reg_file_sb_if.slave rf_if
);

   typedef enum logic {CLEAR, RUN} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              init_done_q;
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [LEN-1:0]    mem_q [DEPTH];

   logic [LEN-1:0]    rs1_data_q, rs2_data_q;
   logic              rs1_busy_q, rs2_busy_q;
   logic [LEN:0]      rd1_d, rd2_d;

   logic              wr_ok;
   logic              claim_ok;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [LEN-1:0]    mem_wdata;

   function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
      return ZERO_REG && (idx == '0);
   endfunction

   // Returns {busy, data} as seen by a read captured this cycle.
   function automatic logic [LEN:0] read_port(input logic [ADDR_W-1:0] idx);
      logic [LEN-1:0] data;
      logic           busy;
      data = mem_q[idx];
      busy = busy_q[idx];
`ifdef RF_BYPASS_EN
      if (wr_ok && (rf_if.wr_rd == idx)) begin
         data = rf_if.wr_data;
         busy = claim_ok && (rf_if.claim_rd == idx);
      end
`endif
      if (is_zero(idx)) begin
         data = '0;
         busy = 1'b0;
      end
      return {busy, data};
   endfunction

   assign wr_ok    = (state_q == RUN) && rf_if.wr_en && !is_zero(rf_if.wr_rd);
   assign claim_ok = (state_q == RUN) && rf_if.claim_en && !is_zero(rf_if.claim_rd);

   // Claim is applied after the write so a same-index claim leaves the entry busy.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok)    busy_d[rf_if.wr_rd]    = 1'b0;
      if (claim_ok) busy_d[rf_if.claim_rd] = 1'b1;
   end

   always_comb begin
      rd1_d = read_port(rf_if.rs1);
      rd2_d = read_port(rf_if.rs2);
   end

   // Single write port shared by the clear sweep and write-back, so the array can map to RAM.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = rf_if.wr_rd;
      mem_wdata = rf_if.wr_data;
      if (rst_n && rf_if.rdy_in) begin
         if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
         end else if (wr_ok) begin
            mem_we    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         busy_q      <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         rs1_busy_q  <= 1'b0;
         rs2_busy_q  <= 1'b0;
      end else if (rf_if.rdy_in) begin
         case (state_q)
            CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                  state_q     <= RUN;
                  init_done_q <= 1'b1;
               end
            end
            RUN: begin
               busy_q <= busy_d;
               if (rf_if.rd_en) begin
                  rs1_data_q <= rd1_d[LEN-1:0];
                  rs1_busy_q <= rd1_d[LEN];
                  rs2_data_q <= rd2_d[LEN-1:0];
                  rs2_busy_q <= rd2_d[LEN];
               end
            end
            default: state_q <= CLEAR;
         endcase
      end
   end

   assign rf_if.rs1_data  = rs1_data_q;
   assign rf_if.rs2_data  = rs2_data_q;
   assign rf_if.rs1_busy  = rs1_busy_q;
   assign rf_if.rs2_busy  = rs2_busy_q;
   assign rf_if.init_done = init_done_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (DEPTH 32, ZERO_REG 1); expectations follow RF_BYPASS_EN.
module tb_reg_file_sb;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n;

   reg_file_sb_if #(.LEN(32), .ADDR_W(5)) rf ();

   reg_file_sb #(.LEN(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf_if (rf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rf.rd_en    = 1'b0;
      rf.claim_en = 1'b0;
      rf.wr_en    = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [4:0] b);
      rf.rd_en = 1'b1;
      rf.rs1   = a;
      rf.rs2   = b;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      rf.wr_en   = 1'b1;
      rf.wr_rd   = a;
      rf.wr_data = d;
   endtask

   task automatic claim(input logic [4:0] a);
      rf.claim_en = 1'b1;
      rf.claim_rd = a;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      rf.rdy_in = 1'b1;
      rf.rs1 = '0; rf.rs2 = '0; rf.claim_rd = '0; rf.wr_rd = '0; rf.wr_data = '0;
      idle();
      repeat (2) tick();
      chk("rst_rs1_data", rf.rs1_data, 0);
      chk("rst_rs2_data", rf.rs2_data, 0);
      chk("rst_rs1_busy", rf.rs1_busy, 0);
      chk("rst_rs2_busy", rf.rs2_busy, 0);
      chk("rst_init_done", rf.init_done, 0);

      // Sweep with port traffic that must be ignored.
      rst_n = 1'b1;
      rd(7, 7); wr(7, 32'hFFFF_FFFF); claim(7);
      n = 0;
      while (!rf.init_done && n < 200) begin tick(); n++; end
      chk("sweep_len", n, 32);
      chk("sweep_rd_quiet", rf.rs1_data, 0);
      idle(); rd(7, 7); tick();
      chk("post_sweep_rd7", rf.rs1_data, 0);
      chk("post_sweep_busy7", rf.rs1_busy, 0);

      idle(); wr(5, 32'hDEAD_BEEF); tick();
      idle(); rd(5, 5); tick();
      chk("wr5_rs1", rf.rs1_data, 32'hDEAD_BEEF);
      chk("wr5_rs2", rf.rs2_data, 32'hDEAD_BEEF);
      chk("wr5_busy1", rf.rs1_busy, 0);
      chk("wr5_busy2", rf.rs2_busy, 0);

      idle(); wr(0, 32'h1234); claim(0); tick();
      idle(); rd(0, 5); tick();
      chk("zero_data", rf.rs1_data, 0);
      chk("zero_busy", rf.rs1_busy, 0);
      chk("zero_rs2", rf.rs2_data, 32'hDEAD_BEEF);

      idle(); rf.rs1 = 9; rf.rs2 = 9; tick();
      chk("hold_rs1", rf.rs1_data, 0);
      chk("hold_rs2", rf.rs2_data, 32'hDEAD_BEEF);

      idle(); claim(9); rd(9, 9); tick();
      chk("claim_no_fwd", rf.rs1_busy, 0);
      idle(); rd(9, 9); tick();
      chk("claim9_busy1", rf.rs1_busy, 1);
      chk("claim9_busy2", rf.rs2_busy, 1);

      idle(); wr(9, 32'h55); tick();
      idle(); rd(9, 9); tick();
      chk("wr9_data", rf.rs1_data, 32'h55);
      chk("wr9_busy", rf.rs1_busy, 0);

      idle(); wr(9, 32'h77); claim(9); tick();
      idle(); rd(9, 9); tick();
      chk("clmwr9_data", rf.rs1_data, 32'h77);
      chk("clmwr9_busy", rf.rs1_busy, 1);

      // Entry 3 holds 0x11 and is busy before the same-cycle write/read.
      idle(); wr(3, 32'h11); claim(3); tick();
      idle(); wr(3, 32'hA5A5_A5A5); rd(3, 3); tick();
`ifdef RF_BYPASS_EN
      chk("byp_data", rf.rs1_data, 32'hA5A5_A5A5);
      chk("byp_busy", rf.rs1_busy, 0);
`else
      chk("nobyp_data", rf.rs1_data, 32'h11);
      chk("nobyp_busy", rf.rs1_busy, 1);
`endif
      idle(); rd(3, 3); tick();
      chk("after_byp_data", rf.rs2_data, 32'hA5A5_A5A5);
      chk("after_byp_busy", rf.rs2_busy, 0);

      idle(); wr(3, 32'h0B); claim(3); rd(3, 3); tick();
`ifdef RF_BYPASS_EN
      chk("bypclm_data", rf.rs1_data, 32'h0B);
      chk("bypclm_busy", rf.rs1_busy, 1);
`else
      chk("nobypclm_data", rf.rs1_data, 32'hA5A5_A5A5);
      chk("nobypclm_busy", rf.rs1_busy, 0);
`endif
      idle(); rd(3, 3); tick();
      chk("clm3_data", rf.rs1_data, 32'h0B);
      chk("clm3_busy", rf.rs1_busy, 1);

      // rdy_in low: read, write and claim all dropped.
      idle(); rf.rdy_in = 1'b0; rd(5, 5); wr(5, 32'hCAFE); claim(5); tick();
      chk("freeze_rs1", rf.rs1_data, 32'h0B);
      chk("freeze_busy", rf.rs1_busy, 1);
      rf.rdy_in = 1'b1; idle(); rd(5, 5); tick();
      chk("freeze_wr_drop", rf.rs1_data, 32'hDEAD_BEEF);
      chk("freeze_clm_drop", rf.rs1_busy, 0);

      idle(); claim(4); tick();
      idle(); rd(4, 4); tick();
      chk("claim4_busy", rf.rs1_busy, 1);
      idle(); rst_n = 1'b0; tick();
      chk("rst_mid_data", rf.rs1_data, 0);
      chk("rst_mid_busy", rf.rs1_busy, 0);
      chk("rst_mid_init", rf.init_done, 0);

      // Partial sweep, reset again, then a sweep stretched by 5 stalled cycles.
      rst_n = 1'b1;
      repeat (10) tick();
      chk("partial_init", rf.init_done, 0);
      rst_n = 1'b0; tick();
      rst_n = 1'b1;
      n = 0;
      while (!rf.init_done && n < 200) begin
         rf.rdy_in = !(n >= 10 && n < 15);
         tick();
         n++;
      end
      rf.rdy_in = 1'b1;
      chk("stall_sweep_len", n, 37);
      idle(); rd(4, 5); tick();
      chk("resweep_busy4", rf.rs1_busy, 0);
      chk("resweep_data4", rf.rs1_data, 0);
      chk("resweep_data5", rf.rs2_data, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
